sqrt_pipe: RTL and testbench

SQRT_PIPE -- requirements
Module: sqrt_pipe

---
 rtl/sqrt_pkg.sv | 32 +++
 rtl/sqrt_pipe_stage.sv | 113 +++++++++++
 rtl/sqrt_pipe.sv | 102 ++++++++++
 tb/tb_sqrt_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_pkg -- shared constants and width helpers for the pipelined square root.
//
// Configuration macro:
//   SQRT_REMAINDER_EN : when defined, the final remainder is kept and exported
//                       on rem_o. When undefined, the remainder port and the
//                       final-stage remainder register are removed.
// -----------------------------------------------------------------------------
package sqrt_pkg;

`ifdef SQRT_REMAINDER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  // A radicand of in_width bits has a root of half that width.
  function automatic int root_width(input int in_width);
    return in_width / 2;
  endfunction

  // The remainder data - root^2 never exceeds 2*root, so one extra bit suffices.
  function automatic int rem_width(input int in_width);
    return in_width / 2 + 1;
  endfunction

  // One root bit is resolved per stage.
  function automatic int num_stages(input int in_width);
    return root_width(in_width);
  endfunction

endpackage

// File: rtl/sqrt_pipe_stage.sv
// -----------------------------------------------------------------------------
// sqrt_pipe_stage -- one stage of the digit-by-digit (restoring) square root.
// Resolves one root bit, MSB first, and registers the result.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en_i              advance; when low every register holds
//   flush_i           clears the valid bit on the next edge (wins over en_i)
//   valid_i/valid_o   slot valid in / out
//   data_i/data_o     radicand travelling with the slot
//   r_i/r_o           partial remainder (REM_WIDTH+1 bits)
//   q_i/q_o           partial root
//   tag_i/tag_o       sideband tag
//
// Configuration macro SQRT_REMAINDER_EN (via sqrt_pkg::REM_EN): when
// undefined, the last stage carries no remainder register.
// -----------------------------------------------------------------------------
module sqrt_pipe_stage
  import sqrt_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int TAG_WIDTH = 4,
  parameter int STAGE_IDX = 0,
  localparam int RW  = root_width(IN_WIDTH),
  localparam int RIW = rem_width(IN_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic [IN_WIDTH-1:0]  data_i,
  input  logic [RIW-1:0]       r_i,
  input  logic [RW-1:0]        q_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 valid_o,
  output logic [IN_WIDTH-1:0]  data_o,
  output logic [RIW-1:0]       r_o,
  output logic [RW-1:0]        q_o,
  output logic [TAG_WIDTH-1:0] tag_o
);

  localparam int  CW     = RIW + 2;
  localparam int  LSB    = IN_WIDTH - 2 - 2 * STAGE_IDX;
  localparam bit  KEEP_R = (STAGE_IDX != RW - 1) || REM_EN;

  logic [CW-1:0]        r_sh;
  logic [CW-1:0]        t_val;
  logic [CW-1:0]        r_full;
  logic                 ge;
  logic [RIW-1:0]       r_d;
  logic [RW-1:0]        q_d;

  logic                 valid_q;
  logic [IN_WIDTH-1:0]  data_q;
  logic [RW-1:0]        q_q;
  logic [TAG_WIDTH-1:0] tag_q;

  // Bring down the next pair of radicand bits and try subtracting 4q+1.
  assign r_sh   = {r_i, data_i[LSB +: 2]};
  assign t_val  = {2'b00, q_i, 2'b01};
  assign ge     = (r_sh >= t_val);
  assign r_full = ge ? (r_sh - t_val) : r_sh;
  assign r_d    = r_full[RIW-1:0];
  // Before stage k the partial root has only k bits, so its MSB is still zero
  // and the shift loses nothing.
  assign q_d    = {q_i[RW-2:0], ge};

  // The remainder is bounded by 2q, so the bits above RIW are always zero.
  logic unused_bits;
  assign unused_bits = ^{r_full[CW-1:RIW], q_i[RW-1]};

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value, giving a true shift pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          valid_q <= 1'b0;
    else if (flush_i) valid_q <= 1'b0;
    else if (en_i)    valid_q <= valid_i;
  end

  // NOTE: the datapath registers are reset as well as gated by the incoming
  // valid bit, so outputs are never X and idle slots do not toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      q_q    <= '0;
      tag_q  <= '0;
    end else if (en_i && valid_i) begin
      data_q <= data_i;
      q_q    <= q_d;
      tag_q  <= tag_i;
    end
  end

  if (KEEP_R) begin : g_rem
    logic [RIW-1:0] r_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                  r_q <= '0;
      else if (en_i && valid_i) r_q <= r_d;
    end
    assign r_o = r_q;
  end else begin : g_no_rem
    logic unused_r;
    assign unused_r = ^r_d;
    assign r_o      = '0;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign q_o     = q_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/sqrt_pipe.sv
// -----------------------------------------------------------------------------
// sqrt_pipe -- fully pipelined integer square root, ROOT_WIDTH stages,
// one result per cycle, fixed latency of ROOT_WIDTH advancing cycles.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   en_pipe_i  global advance; when 0 every stage holds and valid_i is ignored
//   flush_i    clears every valid bit on the next edge (priority over valid_i)
//   valid_i    data_i / tag_i valid
//   data_i     unsigned radicand, IN_WIDTH bits
//   tag_i      sideband tag, TAG_WIDTH bits
//   valid_o    root_o / rem_o / tag_o valid
//   root_o     floor(sqrt(data))
//   rem_o      data - root^2 (only with SQRT_REMAINDER_EN)
//   tag_o      tag of the result
//   busy_o     any stage holds a valid operand
//
// Configuration macro: SQRT_REMAINDER_EN enables rem_o.
// -----------------------------------------------------------------------------
module sqrt_pipe
  import sqrt_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int TAG_WIDTH = 4,
  localparam int ROOT_WIDTH = root_width(IN_WIDTH),
  localparam int REM_WIDTH  = rem_width(IN_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_pipe_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [IN_WIDTH-1:0]   data_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  valid_o,
  output logic [ROOT_WIDTH-1:0] root_o,
`ifdef SQRT_REMAINDER_EN
  output logic [REM_WIDTH-1:0]  rem_o,
`endif
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  busy_o
);

  localparam int NS  = num_stages(IN_WIDTH);
  localparam int RIW = REM_WIDTH + 1;

  if ((IN_WIDTH % 2) != 0 || IN_WIDTH < 4) begin : g_bad_width
    $error("sqrt_pipe: IN_WIDTH must be even and >= 4");
  end

  // Index k is the input of stage k; index NS is the last stage's register.
  logic [NS:0]                valid_s;
  logic [NS:0][IN_WIDTH-1:0]  data_s;
  logic [NS:0][RIW-1:0]       r_s;
  logic [NS:0][ROOT_WIDTH-1:0] q_s;
  logic [NS:0][TAG_WIDTH-1:0] tag_s;

  assign valid_s[0] = valid_i;
  assign data_s[0]  = data_i;
  assign r_s[0]     = '0;
  assign q_s[0]     = '0;
  assign tag_s[0]   = tag_i;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    sqrt_pipe_stage #(
      .IN_WIDTH  (IN_WIDTH),
      .TAG_WIDTH (TAG_WIDTH),
      .STAGE_IDX (k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en_pipe_i),
      .flush_i (flush_i),
      .valid_i (valid_s[k]),
      .data_i  (data_s[k]),
      .r_i     (r_s[k]),
      .q_i     (q_s[k]),
      .tag_i   (tag_s[k]),
      .valid_o (valid_s[k+1]),
      .data_o  (data_s[k+1]),
      .r_o     (r_s[k+1]),
      .q_o     (q_s[k+1]),
      .tag_o   (tag_s[k+1])
    );
  end

  assign valid_o = valid_s[NS];
  assign root_o  = q_s[NS];
  assign tag_o   = tag_s[NS];
  assign busy_o  = |valid_s[NS:1];

`ifdef SQRT_REMAINDER_EN
  // The final remainder is at most 2*root, so dropping the top bit is lossless.
  assign rem_o = r_s[NS][REM_WIDTH-1:0];
`endif

  // The radicand copy and the spare remainder bit leave the last stage unused.
  logic unused_tail;
  assign unused_tail = ^{data_s[NS], r_s[NS]};

endmodule

// File: tb/tb_sqrt_pipe.sv
// -----------------------------------------------------------------------------
// tb_sqrt_pipe -- self-checking bench for sqrt_pipe at IN_WIDTH=16 and 32.
// A reference model tracks each operand through a fixed number of advancing
// cycles and computes the expected root by arithmetic search.
// -----------------------------------------------------------------------------
module tb_sqrt_pipe;

  localparam int TW  = 4;
  localparam int L16 = 8;
  localparam int L32 = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          en, flush, vin;
  logic [15:0]   d16;
  logic [31:0]   d32;
  logic [TW-1:0] tag;

  logic          valid16, busy16, valid32, busy32;
  logic [7:0]    root16;
  logic [15:0]   root32;
  logic [TW-1:0] tag16, tag32;
`ifdef SQRT_REMAINDER_EN
  logic [8:0]    rem16;
  logic [16:0]   rem32;
`endif

  sqrt_pipe #(.IN_WIDTH(16), .TAG_WIDTH(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_pipe_i (en),
    .flush_i   (flush),
    .valid_i   (vin),
    .data_i    (d16),
    .tag_i     (tag),
    .valid_o   (valid16),
    .root_o    (root16),
`ifdef SQRT_REMAINDER_EN
    .rem_o     (rem16),
`endif
    .tag_o     (tag16),
    .busy_o    (busy16)
  );

  sqrt_pipe #(.IN_WIDTH(32), .TAG_WIDTH(TW)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .en_pipe_i (en),
    .flush_i   (flush),
    .valid_i   (vin),
    .data_i    (d32),
    .tag_i     (tag),
    .valid_o   (valid32),
    .root_o    (root32),
`ifdef SQRT_REMAINDER_EN
    .rem_o     (rem32),
`endif
    .tag_o     (tag32),
    .busy_o    (busy32)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint unsigned got,
                       input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Largest r with r*r <= d, by binary search.
  function automatic longint unsigned isqrt(input longint unsigned d);
    longint unsigned lo = 0;
    longint unsigned hi = 64'hFFFF_FFFF;
    longint unsigned mid;
    while (lo < hi) begin
      mid = lo + (hi - lo + 1) / 2;
      if (mid * mid <= d) lo = mid;
      else                hi = mid - 1;
    end
    return lo;
  endfunction

  // ---------------- reference model: fixed-latency delay line ----------------
  typedef struct {
    bit              v;
    longint unsigned d;
    int unsigned     t;
  } slot_t;

  slot_t m16[L16];
  slot_t m32[L32];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m16[i]) m16[i] = '{1'b0, 0, 0};
      foreach (m32[i]) m32[i] = '{1'b0, 0, 0};
    end else if (flush) begin
      foreach (m16[i]) m16[i].v = 1'b0;
      foreach (m32[i]) m32[i].v = 1'b0;
    end else if (en) begin
      for (int i = L16 - 1; i > 0; i--) m16[i] = m16[i-1];
      for (int i = L32 - 1; i > 0; i--) m32[i] = m32[i-1];
      m16[0] = '{vin, longint'(d16), int'(tag)};
      m32[0] = '{vin, longint'(d32), int'(tag)};
    end
  end

  function automatic bit any16();
    bit b = 1'b0;
    foreach (m16[i]) b |= m16[i].v;
    return b;
  endfunction

  function automatic bit any32();
    bit b = 1'b0;
    foreach (m32[i]) b |= m32[i].v;
    return b;
  endfunction

  // Continuous monitor, sampled on the falling edge.
  always @(negedge clk) begin
    longint unsigned r;
    if (!rst) begin
      check("valid16", valid16, m16[L16-1].v);
      check("busy16", busy16, any16());
      if (m16[L16-1].v) begin
        r = isqrt(m16[L16-1].d);
        check("root16", root16, r);
        check("tag16", tag16, m16[L16-1].t);
`ifdef SQRT_REMAINDER_EN
        check("rem16", rem16, m16[L16-1].d - r * r);
`endif
      end
      check("valid32", valid32, m32[L32-1].v);
      check("busy32", busy32, any32());
      if (m32[L32-1].v) begin
        r = isqrt(m32[L32-1].d);
        check("root32", root32, r);
        check("tag32", tag32, m32[L32-1].t);
`ifdef SQRT_REMAINDER_EN
        check("rem32", rem32, m32[L32-1].d - r * r);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [15:0] pick16();
    int unsigned n;
    n = $urandom_range(1, 255);
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'(n * n);
      3:       return 16'(n * n - 1);
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] pick32();
    longint unsigned n;
    n = longint'($urandom_range(1, 65535));
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'(n * n);
      3:       return 32'(n * n - 1);
      default: return $urandom;
    endcase
  endfunction

  // Drive one cycle of inputs, then wait for the next falling edge.
  task automatic step(input bit v, input logic [15:0] d, input logic [TW-1:0] t,
                      input bit e = 1'b1, input bit f = 1'b0);
    vin   = v;
    d16   = d;
    tag   = t;
    en    = e;
    flush = f;
    d32   = pick32();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, '0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; vin = 1'b0;
    d16 = '0; d32 = '0; tag = '0;
    repeat (2) @(negedge clk);
    check("rst_valid16", valid16, 0);
    check("rst_root16", root16, 0);
    check("rst_tag16", tag16, 0);
    check("rst_busy16", busy16, 0);
    check("rst_valid32", valid32, 0);
    rst = 1'b0;
    @(negedge clk);

    // 144 with tag 3: result appears exactly 8 advancing cycles later.
    step(1'b1, 16'd144, 4'd3);
    idle(6);
    check("lat7_valid", valid16, 0);
    idle(1);
    check("lat8_valid", valid16, 1);
    check("lat8_root", root16, 12);
    check("lat8_tag", tag16, 3);
`ifdef SQRT_REMAINDER_EN
    check("lat8_rem", rem16, 0);
`endif

    // Back-to-back operands 143, 65535, 0.
    step(1'b1, 16'd143, 4'd1);
    step(1'b1, 16'hFFFF, 4'd2);
    step(1'b1, 16'd0, 4'd4);
    idle(5);
    check("b2b0_root", root16, 11);
    check("b2b0_tag", tag16, 1);
`ifdef SQRT_REMAINDER_EN
    check("b2b0_rem", rem16, 22);
`endif
    idle(1);
    check("b2b1_valid", valid16, 1);
    check("b2b1_root", root16, 255);
`ifdef SQRT_REMAINDER_EN
    check("b2b1_rem", rem16, 510);
`endif
    idle(1);
    check("b2b2_valid", valid16, 1);
    check("b2b2_root", root16, 0);
    check("b2b2_tag", tag16, 4);
`ifdef SQRT_REMAINDER_EN
    check("b2b2_rem", rem16, 0);
`endif
    idle(1);
    check("b2b_done", valid16, 0);

    // Stream of 8 with a 3-cycle stall in the middle; valid_i asserted
    // during the stall must be ignored.
    for (int i = 0; i < 8; i++) begin
      if (i == 4) repeat (3) step(1'b1, 16'd999, 4'd15, 1'b0);
      step(1'b1, pick16(), 4'(i));
    end
    idle(12);

    // Flush with 5 in flight and a new operand offered in the same cycle.
    for (int i = 0; i < 5; i++) step(1'b1, pick16(), 4'(i + 8));
    step(1'b1, 16'd500, 4'd7, 1'b1, 1'b1);
    check("flush_busy16", busy16, 0);
    check("flush_valid16", valid16, 0);
    check("flush_busy32", busy32, 0);
    idle(18);

    // Asynchronous reset between edges with 4 in flight.
    for (int i = 0; i < 4; i++) step(1'b1, pick16(), 4'(i + 1));
    vin = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("arst_valid16", valid16, 0);
    check("arst_root16", root16, 0);
    check("arst_busy16", busy16, 0);
    check("arst_valid32", valid32, 0);
    rst = 1'b0;
    @(negedge clk);
    step(1'b1, 16'd1, 4'd9);
    idle(6);
    check("post_rst_early", valid16, 0);
    idle(1);
    check("post_rst_valid", valid16, 1);
    check("post_rst_root", root16, 1);
    check("post_rst_tag", tag16, 9);
`ifdef SQRT_REMAINDER_EN
    check("post_rst_rem", rem16, 0);
`endif

    // Random sweep with stalls and occasional flushes.
    repeat (600) begin
      step($urandom_range(0, 9) != 0, pick16(), 4'($urandom),
           $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
    end
    idle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
